// File: rtl/gp_timer_arbiter.sv
// gp_timer_arbiter: shares one down-counter timer between NUM_REQ requesters.
// Grants round-robin and loads the winner's delay. Counts to zero and then
// pulses that requester's DONE for one cycle.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_IDLE   | timer free; arbitrate among REQ on every edge
// S_RUN    | timer owned by last_q; COUNT decrements toward zero
// S_EXPIRE | DONE[owner] high for this single cycle; back to IDLE next edge
module gp_timer_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 14
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [NUM_REQ-1:0]         REQ,
    input  logic [NUM_REQ*WIDTH-1:0]   DLY,
    input  logic                       CANCEL,
    output logic [NUM_REQ-1:0]         GNT,
    output logic [NUM_REQ-1:0]         DONE,
    output logic                       BUSY,
    output logic [WIDTH-1:0]           COUNT
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_EXPIRE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [NUM_REQ-1:0]   done_q, done_d;
    logic [WIDTH-1:0]     count_q, count_d;
    logic [IDX_W-1:0]     last_q, last_d;

    logic [WIDTH-1:0]     dly_arr [NUM_REQ];
    logic                 sel_valid;
    logic [IDX_W-1:0]     sel_idx;

    // Index of base+off wrapped into 0..NUM_REQ-1 (off never exceeds NUM_REQ).
    function automatic logic [IDX_W-1:0] wrap_idx(input int unsigned base,
                                                  input int unsigned off);
        int unsigned s;
        s = base + off;
        if (s >= NUM_REQ) begin
            s = s - NUM_REQ;
        end
        return IDX_W'(s);
    endfunction

    // Unpack the flat delay bus into one load value per requester.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            dly_arr[i] = DLY[i*WIDTH +: WIDTH];
        end
    end

    // Round-robin pick: first REQ found searching upward from last_q+1.
    // The last slot examined is last_q itself, so a lone holder is re-eligible.
    always_comb begin
        logic [IDX_W-1:0] idx;
        sel_valid = 1'b0;
        sel_idx   = '0;
        idx       = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = wrap_idx(32'(last_q), k);
            if (!sel_valid && REQ[idx]) begin
                sel_valid = 1'b1;
                sel_idx   = idx;
            end
        end
    end

    // Next-state and registered-output logic; the owner is always last_q.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        count_d = count_q;
        last_d  = last_q;

        case (state_q)
            S_IDLE: begin
                gnt_d   = '0;
                count_d = '0;
                if (sel_valid) begin
                    gnt_d[sel_idx] = 1'b1;
                    count_d        = dly_arr[sel_idx];
                    last_d         = sel_idx;
                    state_d        = S_RUN;
                end
            end
            S_RUN: begin
                // Abort takes priority over expiry, so a withdrawn request
                // reaching zero on the same edge never sees DONE.
                if (CANCEL || !REQ[last_q]) begin
                    gnt_d   = '0;
                    count_d = '0;
                    state_d = S_IDLE;
                end else if (count_q == '0) begin
                    gnt_d          = '0;
                    done_d[last_q] = 1'b1;
                    state_d        = S_EXPIRE;
                end else begin
                    count_d = count_q - WIDTH'(1);
                end
            end
            S_EXPIRE: begin
                gnt_d   = '0;
                count_d = '0;
                state_d = S_IDLE;
            end
            default: begin
                gnt_d   = '0;
                count_d = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset hands first grant to requester 0.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            done_q  <= '0;
            count_q <= '0;
            last_q  <= IDX_W'(NUM_REQ - 1);
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            count_q <= count_d;
            last_q  <= last_d;
        end
    end

    assign GNT   = gnt_q;
    assign DONE  = done_q;
    assign COUNT = count_q;
    assign BUSY  = (state_q != S_IDLE);

endmodule

// File: tb/tb_gp_timer_arbiter.sv
// Scoreboard bench for gp_timer_arbiter: stimulus pushes expected grant,
// expiry and abort events; a negedge monitor pops and compares them.
module tb_gp_timer_arbiter;

    localparam int N = 4;
    localparam int W = 14;
    localparam int K_GRANT = 0;
    localparam int K_DONE  = 1;
    localparam int K_ABORT = 2;

    logic           CLK = 1'b0;
    logic           RST = 1'b0;
    logic [N-1:0]   REQ = '0;
    logic [N*W-1:0] DLY = '0;
    logic           CANCEL = 1'b0;
    logic [N-1:0]   GNT;
    logic [N-1:0]   DONE;
    logic           BUSY;
    logic [W-1:0]   COUNT;

    typedef struct {
        int kind;
        int vec;
        int val;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    gp_timer_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
        .CLK    (CLK),
        .RST    (RST),
        .REQ    (REQ),
        .DLY    (DLY),
        .CANCEL (CANCEL),
        .GNT    (GNT),
        .DONE   (DONE),
        .BUSY   (BUSY),
        .COUNT  (COUNT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic push(input int kind, input int vec, input int val);
        exp_t e;
        e.kind = kind;
        e.vec  = vec;
        e.val  = val;
        sb_q.push_back(e);
    endtask

    task automatic pop_cmp(input int kind, input int vec, input int val);
        exp_t e;
        if (sb_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_event: kind %0d vec %0h val %0d with empty scoreboard (t=%0t)",
                     kind, vec, val, $time);
        end else begin
            e = sb_q.pop_front();
            chk("event_kind", kind, e.kind);
            chk("event_vec", vec, e.vec);
            chk("event_val", val, e.val);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_dly(input int i, input int v);
        DLY[i*W +: W] = W'(v);
    endtask

    task automatic reset_dut();
        REQ    = '0;
        CANCEL = 1'b0;
        RST    = 1'b1;
        ticks(2);
        RST    = 1'b0;
    endtask

    // Monitor: turns GNT/DONE edges into events and checks invariants.
    logic [N-1:0] prev_gnt = '0;
    int           prev_count = 0;
    int           run_len = 0;

    always @(negedge CLK) begin
        if (RST) begin
            prev_gnt   = '0;
            prev_count = 0;
            run_len    = 0;
        end else begin
            chk("busy_consistent", int'(BUSY), int'((GNT != 0) || (DONE != 0)));
            chk("gnt_done_onehot", int'(($countones(GNT) <= 1) && ($countones(DONE) <= 1)
                                       && !((GNT != 0) && (DONE != 0))), 1);
            if (GNT != 0 && prev_gnt == 0) begin
                pop_cmp(K_GRANT, int'(GNT), int'(COUNT));
                run_len = 1;
            end else if (GNT != 0 && GNT == prev_gnt) begin
                chk("count_dec", int'(COUNT), prev_count - 1);
                run_len++;
            end else if (GNT != 0) begin
                n_checks++;
                $display("FAIL gnt_switch: got %0h expected %0h", GNT, prev_gnt);
            end
            if (GNT == 0 && prev_gnt != 0) begin
                if (DONE != 0) pop_cmp(K_DONE, int'(DONE), run_len);
                else           pop_cmp(K_ABORT, int'(prev_gnt), run_len);
            end else if (DONE != 0) begin
                n_checks++;
                $display("FAIL stray_done: got %0h expected 0", DONE);
            end
            prev_gnt   = GNT;
            prev_count = int'(COUNT);
        end
    end

    initial begin
        // Reset state
        #1 RST = 1'b1;
        #1;
        chk("rst_gnt", int'(GNT), 0);
        chk("rst_done", int'(DONE), 0);
        chk("rst_count", int'(COUNT), 0);
        chk("rst_busy", int'(BUSY), 0);
        ticks(2);
        RST = 1'b0;
        ticks(2);

        // 1: single requester, DLY=3 -> GNT 4 cycles, then DONE
        push(K_GRANT, 4'b0001, 3);
        push(K_DONE, 4'b0001, 4);
        set_dly(0, 3);
        REQ = 4'b0001;
        ticks(6);
        REQ = '0;
        chk("t1_busy_after", int'(BUSY), 0);
        chk("t1_count_after", int'(COUNT), 0);
        ticks(2);

        // 2: all requesting, DLY=1 -> grants 0,1,2,3,0
        reset_dut();
        for (int i = 0; i < N; i++) set_dly(i, 1);
        push(K_GRANT, 4'b0001, 1); push(K_DONE, 4'b0001, 2);
        push(K_GRANT, 4'b0010, 1); push(K_DONE, 4'b0010, 2);
        push(K_GRANT, 4'b0100, 1); push(K_DONE, 4'b0100, 2);
        push(K_GRANT, 4'b1000, 1); push(K_DONE, 4'b1000, 2);
        push(K_GRANT, 4'b0001, 1); push(K_DONE, 4'b0001, 2);
        REQ = 4'b1111;
        ticks(20);
        REQ = '0;
        ticks(3);

        // 3: CANCEL at COUNT=6
        reset_dut();
        set_dly(1, 10);
        push(K_GRANT, 4'b0010, 10);
        push(K_ABORT, 4'b0010, 5);
        REQ = 4'b0010;
        ticks(5);
        chk("t3_count_at_cancel", int'(COUNT), 6);
        CANCEL = 1'b1;
        tick();
        chk("t3_gnt_after_cancel", int'(GNT), 0);
        chk("t3_count_after_cancel", int'(COUNT), 0);
        chk("t3_busy_after_cancel", int'(BUSY), 0);
        CANCEL = 1'b0;
        REQ = '0;
        ticks(3);

        // 4: owner withdraws at COUNT=2, pending requester follows
        reset_dut();
        set_dly(0, 5);
        set_dly(2, 2);
        push(K_GRANT, 4'b0001, 5);
        push(K_ABORT, 4'b0001, 4);
        push(K_GRANT, 4'b0100, 2);
        push(K_DONE, 4'b0100, 3);
        REQ = 4'b0101;
        ticks(4);
        chk("t4_count_at_drop", int'(COUNT), 2);
        REQ = 4'b0100;
        ticks(6);
        REQ = '0;
        ticks(3);

        // 5: DLY change after grant is ignored
        reset_dut();
        set_dly(0, 5);
        push(K_GRANT, 4'b0001, 5);
        push(K_DONE, 4'b0001, 6);
        REQ = 4'b0001;
        tick();
        set_dly(0, 1);
        ticks(7);
        REQ = '0;
        ticks(3);

        // 6: async reset mid-RUN, then requester 0 wins first
        reset_dut();
        set_dly(0, 8);
        push(K_GRANT, 4'b0001, 8);
        REQ = 4'b0001;
        ticks(5);
        chk("t6_count_before_rst", int'(COUNT), 4);
        #1 RST = 1'b1;
        #1;
        chk("t6_gnt_in_rst", int'(GNT), 0);
        chk("t6_done_in_rst", int'(DONE), 0);
        chk("t6_count_in_rst", int'(COUNT), 0);
        chk("t6_busy_in_rst", int'(BUSY), 0);
        REQ = 4'b1001;
        set_dly(0, 3);
        set_dly(3, 7);
        push(K_GRANT, 4'b0001, 3);
        push(K_DONE, 4'b0001, 4);
        push(K_GRANT, 4'b1000, 7);
        push(K_DONE, 4'b1000, 8);
        tick();
        RST = 1'b0;
        ticks(16);
        REQ = '0;
        ticks(3);

        for (int i = 0; i < 50 && sb_q.size() != 0; i++) tick();
        chk("scoreboard_drained", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
